// File: rtl/adder_share_pkg.sv
// Shared defaults, payload types and a ring-index helper for the adder-sharing controller.
//   DATA_W_DEF/CNT_W_DEF/NUM_REQ_DEF : default parameter values
//   operand_t / result_t             : signed operand and widened result types at default width
//   tag_t                            : pipeline tag (valid + requester id, sized for up to 8 requesters)
//   rr_wrap()                        : (base + off) modulo n for off < n
package adder_share_pkg;

  localparam int unsigned DATA_W_DEF  = 4;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned TAG_ID_W    = 3;

  typedef logic signed [DATA_W_DEF-1:0] operand_t;
  typedef logic signed [DATA_W_DEF:0]   result_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // Single conditional subtract is enough because base < n and off < n.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    int unsigned s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered search pointer.
//   clk, reset : clock, synchronous active-high reset (pointer -> 0)
//   req        : request vector (already qualified by the caller)
//   advance    : grant was taken this cycle; pointer moves past the winner
//   gnt        : one-hot grant (combinational)
//   gnt_idx    : index of the granted requester (combinational)
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  // First requesting index at or above the pointer, wrapping.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'(rr_wrap(32'(ptr_q), i, NUM_REQ));
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = IDX_W'(rr_wrap(32'(gnt_idx), 1, NUM_REQ));
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one registered signed adder among NUM_REQ requesters.
//   clk, reset             : clock, synchronous active-high reset
//   req_valid/req_a/req_b  : per-requester operation and signed operands
//   req_ready              : one-hot grant; handshake = req_valid & req_ready
//   add_reset/add_a/add_b  : registered drive to the external adder
//   add_c                  : adder result (one cycle after add_a/add_b sampled)
//   resp_valid/resp_id     : one-hot response pulse and its requester index
//   resp_c/resp_ovf        : sign-extended sum and DATA_W-range overflow flag
//   op_count               : completed-operation counter (wraps)
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_b,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            add_reset,
  output logic [DATA_W-1:0]               add_a,
  output logic [DATA_W-1:0]               add_b,
  input  logic [DATA_W:0]                 add_c,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]      resp_id,
  output logic [DATA_W:0]                 resp_c,
  output logic                            resp_ovf,
  output logic [CNT_W-1:0]                op_count
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic                arb_en_c;
  logic [NUM_REQ-1:0]  arb_req_c;
  logic [NUM_REQ-1:0]  arb_gnt_c;
  logic [ID_W-1:0]     arb_idx_c;
  logic                hs_c;

  logic                add_reset_q;
  logic [DATA_W-1:0]   add_a_q, add_a_d;
  logic [DATA_W-1:0]   add_b_q, add_b_d;
  tag_t                s1_q, s1_d;
  tag_t                s2_q, s2_d;
  logic [CNT_W-1:0]    op_count_q, op_count_d;

  // No grants while the controller or the adder is held in reset.
  assign arb_en_c  = !reset && !add_reset_q;
  assign arb_req_c = req_valid & {NUM_REQ{arb_en_c}};
  // Grants only go to valid requesters, so any grant is a handshake.
  assign hs_c      = |arb_gnt_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req_c),
    .advance (hs_c),
    .gnt     (arb_gnt_c),
    .gnt_idx (arb_idx_c)
  );

  // Stage 1 captures the winner's operands; stage 2 tracks the tag while the adder computes.
  always_comb begin
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    s1_d       = '0;
    s2_d       = s1_q;
    op_count_d = op_count_q;
    if (hs_c) begin
      add_a_d  = req_a[arb_idx_c];
      add_b_d  = req_b[arb_idx_c];
      s1_d.valid = 1'b1;
      s1_d.id    = TAG_ID_W'(arb_idx_c);
    end
    if (s2_q.valid) op_count_d = op_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    add_reset_q <= reset;
    if (reset) begin
      add_a_q    <= '0;
      add_b_q    <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      op_count_q <= '0;
    end else begin
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      op_count_q <= op_count_d;
    end
  end

  // Response decode: adder output is already aligned with the stage-2 tag.
  always_comb begin
    resp_valid = '0;
    if (s2_q.valid) resp_valid[resp_id] = 1'b1;
    resp_c   = s2_q.valid ? add_c : '0;
    resp_ovf = s2_q.valid & (add_c[DATA_W] ^ add_c[DATA_W-1]);
  end

  assign resp_id   = ID_W'(s2_q.id);
  assign req_ready = arb_gnt_c;
  assign add_reset = add_reset_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl with a behavioural registered adder attached.
module tb_adder_share_ctrl;

  logic             clk;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0][3:0]  req_a;
  logic [3:0][3:0]  req_b;
  logic [3:0]       req_ready;
  logic             add_reset;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic [4:0]       add_c;
  logic [3:0]       resp_valid;
  logic [1:0]       resp_id;
  logic [4:0]       resp_c;
  logic             resp_ovf;
  logic [15:0]      op_count;

  int n_cmp = 0;
  int n_err = 0;

  adder_share_ctrl #(.NUM_REQ(4), .DATA_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .add_reset  (add_reset),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_c      (add_c),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_c     (resp_c),
    .resp_ovf   (resp_ovf),
    .op_count   (op_count)
  );

  // Registered signed adder, 1-cycle latency.
  always_ff @(posedge clk) begin
    if (add_reset) add_c <= '0;
    else           add_c <= 5'($signed(add_a)) + 5'($signed(add_b));
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    req_valid = 4'h0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Model state for the random section
  int   mptr, gi, idx, n_acc, max_wait;
  bit   gv;
  logic [3:0] eg;
  bit   m1v, m2v;
  int   m1id, m2id, m1sum, m2sum;
  int   wait_cnt [4];

  initial begin
    reset     = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;

    // 1: reset behaviour
    tick();
    check("t1_ready_rst0", int'(req_ready), 0);
    check("t1_resp_valid", int'(resp_valid), 0);
    check("t1_resp_c", int'($signed(resp_c)), 0);
    check("t1_op_count", int'(op_count), 0);
    tick();
    check("t1_ready_rst1", int'(req_ready), 0);
    reset = 1'b0;
    #1;
    check("t1_ready_addrst", int'(req_ready), 0);
    check("t1_add_reset", int'(add_reset), 1);
    req_valid = 4'h0;
    tick();
    check("t1_add_reset_low", int'(add_reset), 0);

    // 2: single requester, negative overflow
    req_valid = 4'b0001;
    req_a[0] = 4'(-8);
    req_b[0] = 4'(-8);
    #1;
    check("t2_ready", int'(req_ready), 1);
    tick();
    req_valid = 4'h0;
    #1;
    check("t2_resp_early", int'(resp_valid), 0);
    tick();
    check("t2_resp_valid", int'(resp_valid), 1);
    check("t2_resp_c", int'($signed(resp_c)), -16);
    check("t2_resp_ovf", int'(resp_ovf), 1);
    check("t2_resp_id", int'(resp_id), 0);
    tick();
    check("t2_resp_gone", int'(resp_valid), 0);
    check("t2_op_count", int'(op_count), 1);

    // 3: all requesters continuously valid for 8 cycles
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 4'(i);
      req_b[i] = 4'(i + 1);
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      req_valid = (cyc < 8) ? 4'hF : 4'h0;
      #1;
      check("t3_ready", int'(req_ready), (cyc < 8) ? (1 << (cyc % 4)) : 0);
      check("t3_resp_valid", int'(resp_valid), (cyc >= 2) ? (1 << ((cyc - 2) % 4)) : 0);
      check("t3_resp_c", int'($signed(resp_c)), (cyc >= 2) ? (2 * ((cyc - 2) % 4) + 1) : 0);
      tick();
    end
    check("t3_op_count", int'(op_count), 8);

    // Move pointer to 2 with a single grant to requester 1
    req_valid = 4'b0010;
    req_a[1] = 4'd0;
    req_b[1] = 4'd0;
    #1;
    check("t4_pre_ready", int'(req_ready), 2);
    tick();
    req_valid = 4'h0;
    tick();
    tick();
    tick();

    // 4: wrap-around search from pointer 2
    req_a[1] = 4'd7;
    req_b[1] = 4'(-8);
    req_a[3] = 4'd0;
    req_b[3] = 4'd7;
    req_valid = 4'b1010;
    #1;
    check("t4_ready_first", int'(req_ready), 8);
    tick();
    req_valid = 4'b0010;
    #1;
    check("t4_ready_second", int'(req_ready), 2);
    tick();
    req_valid = 4'h0;
    #1;
    check("t4_resp3_valid", int'(resp_valid), 8);
    check("t4_resp3_id", int'(resp_id), 3);
    check("t4_resp3_c", int'($signed(resp_c)), 7);
    check("t4_resp3_ovf", int'(resp_ovf), 0);
    tick();
    check("t4_resp1_valid", int'(resp_valid), 2);
    check("t4_resp1_id", int'(resp_id), 1);
    check("t4_resp1_c", int'($signed(resp_c)), -1);
    check("t4_resp1_ovf", int'(resp_ovf), 0);
    tick();
    check("t4_op_count", int'(op_count), 11);

    // 5: reset while an operation is in flight
    req_a[2] = 4'd7;
    req_b[2] = 4'd7;
    req_valid = 4'b0100;
    #1;
    check("t5_ready", int'(req_ready), 4);
    tick();
    req_valid = 4'h0;
    reset = 1'b1;
    #1;
    check("t5_resp_s1", int'(resp_valid), 0);
    tick();
    reset = 1'b0;
    #1;
    check("t5_resp_s2", int'(resp_valid), 0);
    check("t5_op_count", int'(op_count), 0);
    check("t5_add_reset", int'(add_reset), 1);
    tick();
    check("t5_resp_late", int'(resp_valid), 0);
    req_valid = 4'hF;
    #1;
    check("t5_ptr_zero", int'(req_ready), 1);
    req_valid = 4'h0;

    // 6: random traffic against a round-robin model
    mptr = 0; m1v = 0; m2v = 0; m1id = 0; m2id = 0; m1sum = 0; m2sum = 0;
    n_acc = 0; max_wait = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 400 && n_acc < 50; cyc++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        req_a[i] = 4'($urandom_range(0, 15));
        req_b[i] = 4'($urandom_range(0, 15));
      end
      eg = '0; gv = 1'b0; gi = 0;
      for (int off = 0; off < 4; off++) begin
        idx = (mptr + off) % 4;
        if (!gv && req_valid[idx]) begin
          gv = 1'b1;
          gi = idx;
        end
      end
      if (gv) begin
        eg[gi] = 1'b1;
        mptr = (gi + 1) % 4;
      end
      #1;
      check("t6_ready", int'(req_ready), int'(eg));
      check("t6_resp_valid", int'(resp_valid), m2v ? (1 << m2id) : 0);
      check("t6_resp_c", int'($signed(resp_c)), m2v ? m2sum : 0);
      check("t6_resp_ovf", int'(resp_ovf), (m2v && (m2sum < -8 || m2sum > 7)) ? 1 : 0);
      if (m2v) check("t6_resp_id", int'(resp_id), m2id);
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && !eg[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      m2v = m1v; m2id = m1id; m2sum = m1sum;
      m1v = gv; m1id = gi;
      m1sum = gv ? (int'($signed(req_a[gi])) + int'($signed(req_b[gi]))) : 0;
      if (gv) n_acc++;
      tick();
    end
    check("t6_ops_accepted", n_acc, 50);
    req_valid = 4'h0;
    for (int cyc = 0; cyc < 2; cyc++) begin
      #1;
      check("t6_flush_valid", int'(resp_valid), m2v ? (1 << m2id) : 0);
      check("t6_flush_c", int'($signed(resp_c)), m2v ? m2sum : 0);
      m2v = m1v; m2id = m1id; m2sum = m1sum;
      m1v = 1'b0; m1id = 0; m1sum = 0;
      tick();
    end
    check("t6_op_count", int'(op_count), n_acc);
    check("t6_no_starve", (max_wait <= 3) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
